// File: rtl/apb_io_arbiter.sv
// Round-robin 2:1 arbiter onto the shared I/O APB bus; grant->s_psel 1 cycle, pready 3 cycles after request with a zero-wait slave.
// Loser is held with pready low until served; optional access timeout under APB_IO_ARBITER_TIMEOUT_EN.
module apb_io_arbiter #(
   parameter int ADDR_W         = 16,
   parameter int DATA_W         = 8,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              m0_psel,
   input  logic              m0_penable,
   input  logic              m0_pwrite,
   input  logic [ADDR_W-1:0] m0_paddr,
   input  logic [DATA_W-1:0] m0_pwdata,
   output logic [DATA_W-1:0] m0_prdata,
   output logic              m0_pready,
   input  logic              m1_psel,
   input  logic              m1_penable,
   input  logic              m1_pwrite,
   input  logic [ADDR_W-1:0] m1_paddr,
   input  logic [DATA_W-1:0] m1_pwdata,
   output logic [DATA_W-1:0] m1_prdata,
   output logic              m1_pready,
   output logic              s_psel,
   output logic              s_penable,
   output logic              s_pwrite,
   output logic [ADDR_W-1:0] s_paddr,
   output logic [DATA_W-1:0] s_pwdata,
   input  logic [DATA_W-1:0] s_prdata,
   input  logic              s_pready,
   output logic [1:0]        gnt,
   output logic              timeout_err
);

   typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2, DONE = 2'd3} state_t;

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be >= 1");
   end

   state_t            state_q, state_d;
   logic              last_q, last_d;
   logic [1:0]        gnt_q, gnt_d;
   logic              psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
   logic [ADDR_W-1:0] paddr_q, paddr_d;
   logic [DATA_W-1:0] pwdata_q, pwdata_d;
   logic [DATA_W-1:0] m0_prdata_q, m0_prdata_d, m1_prdata_q, m1_prdata_d;
   logic              m0_pready_q, m0_pready_d, m1_pready_q, m1_pready_d;
   logic              pick_m1, to_hit;
   logic [DATA_W-1:0] rsp;
   logic              unused_penable;

   // penable is not part of the request qualification
   assign unused_penable = m0_penable ^ m1_penable;

   // last_q=1 means m1 was served last, so m0 wins a tie
   assign pick_m1 = m1_psel && (!m0_psel || !last_q);
   assign rsp     = s_pready ? s_prdata : '1;

`ifdef APB_IO_ARBITER_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             timeout_q, timeout_d;

   assign cnt_d       = (state_q == ACCESS) ? cnt_q + 1'b1 : '0;
   assign to_hit      = (state_q == ACCESS) && !s_pready && (cnt_q == CNT_LAST);
   assign timeout_err = timeout_q;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end
`else
   assign to_hit      = 1'b0;
   assign timeout_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin : next_state
      state_d = state_q;
      case (state_q)
         IDLE:    if (m0_psel || m1_psel) state_d = SETUP;
         SETUP:   state_d = ACCESS;
         ACCESS:  if (s_pready || to_hit) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin : out_next
      gnt_d       = gnt_q;
      last_d      = last_q;
      psel_d      = psel_q;
      penable_d   = penable_q;
      pwrite_d    = pwrite_q;
      paddr_d     = paddr_q;
      pwdata_d    = pwdata_q;
      m0_prdata_d = m0_prdata_q;
      m1_prdata_d = m1_prdata_q;
      m0_pready_d = 1'b0;
      m1_pready_d = 1'b0;
`ifdef APB_IO_ARBITER_TIMEOUT_EN
      timeout_d   = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (m0_psel || m1_psel) begin
               gnt_d     = pick_m1 ? 2'b10 : 2'b01;
               last_d    = pick_m1;
               psel_d    = 1'b1;
               penable_d = 1'b0;
               pwrite_d  = pick_m1 ? m1_pwrite : m0_pwrite;
               paddr_d   = pick_m1 ? m1_paddr  : m0_paddr;
               pwdata_d  = pick_m1 ? m1_pwdata : m0_pwdata;
            end
         end
         SETUP: penable_d = 1'b1;
         ACCESS: begin
            if (s_pready || to_hit) begin
               psel_d    = 1'b0;
               penable_d = 1'b0;
               if (gnt_q[1]) begin
                  m1_prdata_d = rsp;
                  m1_pready_d = 1'b1;
               end else begin
                  m0_prdata_d = rsp;
                  m0_pready_d = 1'b1;
               end
`ifdef APB_IO_ARBITER_TIMEOUT_EN
               timeout_d = to_hit;
`endif
            end
         end
         DONE:    gnt_d = 2'b00;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         gnt_q       <= 2'b00;
         last_q      <= 1'b1;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         m0_prdata_q <= '0;
         m1_prdata_q <= '0;
         m0_pready_q <= 1'b0;
         m1_pready_q <= 1'b0;
      end else begin
         gnt_q       <= gnt_d;
         last_q      <= last_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         pwrite_q    <= pwrite_d;
         paddr_q     <= paddr_d;
         pwdata_q    <= pwdata_d;
         m0_prdata_q <= m0_prdata_d;
         m1_prdata_q <= m1_prdata_d;
         m0_pready_q <= m0_pready_d;
         m1_pready_q <= m1_pready_d;
      end
   end

   assign gnt       = gnt_q;
   assign s_psel    = psel_q;
   assign s_penable = penable_q;
   assign s_pwrite  = pwrite_q;
   assign s_paddr   = paddr_q;
   assign s_pwdata  = pwdata_q;
   assign m0_prdata = m0_prdata_q;
   assign m1_prdata = m1_prdata_q;
   assign m0_pready = m0_pready_q;
   assign m1_pready = m1_pready_q;

endmodule

// File: tb/tb_apb_io_arbiter.sv
// Bench for apb_io_arbiter: vector table plus hand sequences, completions checked against a scoreboard queue.
module tb_apb_io_arbiter;

   logic        clk = 1'b0;
   logic        n_rst;
   logic        m0_psel, m0_penable, m0_pwrite, m1_psel, m1_penable, m1_pwrite;
   logic [15:0] m0_paddr, m1_paddr, s_paddr;
   logic [7:0]  m0_pwdata, m1_pwdata, m0_prdata, m1_prdata, s_pwdata, s_prdata;
   logic        m0_pready, m1_pready, s_psel, s_penable, s_pwrite, s_pready;
   logic [1:0]  gnt;
   logic        timeout_err;

   int checks = 0;
   int failures = 0;

   // slave model: ready after slv_wait extra access cycles, read data derived from address
   int slv_wait = 0;
   bit slv_en = 1'b1;
   int acc_cnt = 0;

   typedef struct {
      bit          who;
      logic [15:0] addr;
      bit          wr;
      logic [7:0]  wd;
      logic [7:0]  rd;
      bit          to;
   } exp_t;

   typedef struct {
      int          n0;
      int          n1;
      bit          first;
      logic [15:0] a0;
      bit          w0;
      logic [7:0]  d0;
      logic [15:0] a1;
      bit          w1;
      logic [7:0]  d1;
      int          wt;
      int          exp_pen;
   } vec_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   assign s_pready = slv_en && s_psel && s_penable && (acc_cnt == slv_wait);
   assign s_prdata = s_paddr[7:0] ^ 8'hC0;

   always @(posedge clk) begin
      if (s_psel && s_penable && !s_pready) acc_cnt <= acc_cnt + 1;
      else                                   acc_cnt <= 0;
   end

   apb_io_arbiter #(.ADDR_W(16), .DATA_W(8), .TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .n_rst(n_rst),
      .m0_psel(m0_psel), .m0_penable(m0_penable), .m0_pwrite(m0_pwrite),
      .m0_paddr(m0_paddr), .m0_pwdata(m0_pwdata), .m0_prdata(m0_prdata), .m0_pready(m0_pready),
      .m1_psel(m1_psel), .m1_penable(m1_penable), .m1_pwrite(m1_pwrite),
      .m1_paddr(m1_paddr), .m1_pwdata(m1_pwdata), .m1_prdata(m1_prdata), .m1_pready(m1_pready),
      .s_psel(s_psel), .s_penable(s_penable), .s_pwrite(s_pwrite),
      .s_paddr(s_paddr), .s_pwdata(s_pwdata), .s_prdata(s_prdata), .s_pready(s_pready),
      .gnt(gnt), .timeout_err(timeout_err)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   task automatic push(input bit who, input logic [15:0] a, input bit w, input logic [7:0] d, input bit to);
      exp_t e;
      e.who  = who;
      e.addr = a;
      e.wr   = w;
      e.wd   = d;
      e.rd   = to ? 8'hFF : (a[7:0] ^ 8'hC0);
      e.to   = to;
      sb.push_back(e);
   endtask

   // requesters keep psel high until they have seen n0/n1 completions
   task automatic serve(input int n0, input int n1, output int pen);
      int cyc = 0;
      pen = 0;
      while ((n0 > 0 || n1 > 0) && cyc < 200) begin
         @(negedge clk);
         if (s_penable) pen++;
         if (m0_pready && n0 > 0) n0--;
         if (m1_pready && n1 > 0) n1--;
         @(posedge clk); #1;
         m0_penable = m0_psel && (n0 > 0);
         m0_psel    = (n0 > 0);
         m1_penable = m1_psel && (n1 > 0);
         m1_psel    = (n1 > 0);
         cyc++;
      end
      chk("serve_within_budget", 32'(cyc < 200), 32'(1));
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int pen, r0, r1;
      bit cur;
      @(posedge clk); #1;
      slv_wait   = v.wt;
      m0_paddr   = v.a0; m0_pwrite = v.w0; m0_pwdata = v.d0;
      m1_paddr   = v.a1; m1_pwrite = v.w1; m1_pwdata = v.d1;
      m0_psel    = (v.n0 > 0); m0_penable = 1'b0;
      m1_psel    = (v.n1 > 0); m1_penable = 1'b0;
      r0 = v.n0; r1 = v.n1; cur = v.first;
      for (int k = 0; k < v.n0 + v.n1; k++) begin
         if (!cur && r0 == 0) cur = 1'b1;
         else if (cur && r1 == 0) cur = 1'b0;
         if (cur) begin push(1'b1, v.a1, v.w1, v.d1, 1'b0); r1--; end
         else     begin push(1'b0, v.a0, v.w0, v.d0, 1'b0); r0--; end
         cur = !cur;
      end
      serve(v.n0, v.n1, pen);
      chk($sformatf("vec%0d_penable_cycles", idx), 32'(pen), 32'(v.exp_pen));
      @(negedge clk);
      chk($sformatf("vec%0d_idle_gnt", idx), 32'(gnt), 32'(0));
      chk($sformatf("vec%0d_idle_psel", idx), 32'(s_psel), 32'(0));
   endtask

   // completion monitor against the scoreboard
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (n_rst) begin
            if (s_psel && s_penable && s_pready) begin
               if (sb.size() == 0) chk("periph_unexpected_xfer", 32'(1), 32'(0));
               else begin
                  e = sb[0];
                  chk("periph_addr", 32'(s_paddr), 32'(e.addr));
                  chk("periph_write", 32'(s_pwrite), 32'(e.wr));
                  if (e.wr) chk("periph_wdata", 32'(s_pwdata), 32'(e.wd));
                  chk("periph_gnt", 32'(gnt), e.who ? 32'(2) : 32'(1));
               end
            end
            if (m0_pready || m1_pready) begin
               if (sb.size() == 0) chk("pready_unexpected", 32'({m1_pready, m0_pready}), 32'(0));
               else begin
                  e = sb.pop_front();
                  chk("pready_owner", 32'({m1_pready, m0_pready}), e.who ? 32'(2) : 32'(1));
                  chk("prdata", e.who ? 32'(m1_prdata) : 32'(m0_prdata), 32'(e.rd));
                  chk("timeout_flag", 32'(timeout_err), 32'(e.to));
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vt[6];
      int   pen, k, first_rdy, to_at, to_cnt;

      vt[0] = '{n0:0, n1:1, first:1'b1, a0:16'h0000, w0:1'b0, d0:8'h00, a1:16'h0003, w1:1'b0, d1:8'h00, wt:3, exp_pen:4};
      vt[1] = '{n0:1, n1:1, first:1'b0, a0:16'h0010, w0:1'b1, d0:8'h11, a1:16'h0020, w1:1'b1, d1:8'h22, wt:0, exp_pen:2};
      vt[2] = '{n0:2, n1:2, first:1'b0, a0:16'h0040, w0:1'b0, d0:8'h00, a1:16'h0080, w1:1'b1, d1:8'h99, wt:1, exp_pen:8};
      vt[3] = '{n0:1, n1:0, first:1'b0, a0:16'hFFFF, w0:1'b1, d0:8'hFF, a1:16'h0000, w1:1'b0, d1:8'h00, wt:2, exp_pen:3};
      vt[4] = '{n0:1, n1:1, first:1'b1, a0:16'h1234, w0:1'b0, d0:8'h00, a1:16'hABCD, w1:1'b0, d1:8'h00, wt:0, exp_pen:2};
      vt[5] = '{n0:0, n1:2, first:1'b1, a0:16'h0000, w0:1'b0, d0:8'h00, a1:16'h0200, w1:1'b1, d1:8'h3C, wt:0, exp_pen:2};

      n_rst = 1'b0;
      m0_psel = 0; m0_penable = 0; m0_pwrite = 0; m0_paddr = '0; m0_pwdata = '0;
      m1_psel = 0; m1_penable = 0; m1_pwrite = 0; m1_paddr = '0; m1_pwdata = '0;

      repeat (2) @(negedge clk);
      chk("rst_gnt", 32'(gnt), 32'(0));
      chk("rst_psel", 32'(s_psel), 32'(0));
      chk("rst_penable", 32'(s_penable), 32'(0));
      chk("rst_pwrite", 32'(s_pwrite), 32'(0));
      chk("rst_paddr", 32'(s_paddr), 32'(0));
      chk("rst_pwdata", 32'(s_pwdata), 32'(0));
      chk("rst_m0_pready", 32'(m0_pready), 32'(0));
      chk("rst_m1_pready", 32'(m1_pready), 32'(0));
      chk("rst_m0_prdata", 32'(m0_prdata), 32'(0));
      chk("rst_m1_prdata", 32'(m1_prdata), 32'(0));
      chk("rst_timeout", 32'(timeout_err), 32'(0));
      #1 n_rst = 1'b1;

      // cycle-exact latency for a zero-wait m0 write
      @(posedge clk); #1;
      m0_psel = 1; m0_pwrite = 1; m0_paddr = 16'h0100; m0_pwdata = 8'h5A;
      push(1'b0, 16'h0100, 1'b1, 8'h5A, 1'b0);
      @(negedge clk);
      chk("lat_T_psel", 32'(s_psel), 32'(0));
      @(posedge clk); #1; m0_penable = 1;
      @(negedge clk);
      chk("lat_T1_psel", 32'(s_psel), 32'(1));
      chk("lat_T1_penable", 32'(s_penable), 32'(0));
      chk("lat_T1_gnt", 32'(gnt), 32'(1));
      @(negedge clk);
      chk("lat_T2_penable", 32'(s_penable), 32'(1));
      chk("lat_T2_paddr", 32'(s_paddr), 32'(16'h0100));
      chk("lat_T2_pwdata", 32'(s_pwdata), 32'(8'h5A));
      chk("lat_T2_gnt", 32'(gnt), 32'(1));
      @(negedge clk);
      chk("lat_T3_m0_pready", 32'(m0_pready), 32'(1));
      chk("lat_T3_gnt", 32'(gnt), 32'(1));
      chk("lat_T3_psel", 32'(s_psel), 32'(0));
      @(posedge clk); #1; m0_psel = 0; m0_penable = 0;
      @(negedge clk);
      chk("lat_T4_m0_pready", 32'(m0_pready), 32'(0));
      chk("lat_T4_gnt", 32'(gnt), 32'(0));

      for (int i = 0; i < 6; i++) run_vec(i, vt[i]);

      // reset in the middle of an access phase, request still pending
      @(posedge clk); #1;
      slv_wait = 10; m1_psel = 1; m1_pwrite = 0; m1_paddr = 16'h0030;
      k = 0;
      do begin @(negedge clk); k++; end while (!s_penable && k < 10);
      chk("rst_mid_reached_access", 32'(s_penable), 32'(1));
      #1 n_rst = 1'b0; m1_penable = 1;
      #1;
      chk("rst_mid_psel_async", 32'(s_psel), 32'(0));
      chk("rst_mid_penable_async", 32'(s_penable), 32'(0));
      chk("rst_mid_gnt_async", 32'(gnt), 32'(0));
      @(negedge clk);
      chk("rst_mid_no_pready", 32'({m1_pready, m0_pready}), 32'(0));
      chk("rst_mid_psel", 32'(s_psel), 32'(0));
      slv_wait = 0;
      push(1'b1, 16'h0030, 1'b0, 8'h00, 1'b0);
      #1 n_rst = 1'b1;
      serve(0, 1, pen);
      chk("rst_mid_regrant_penable", 32'(pen), 32'(1));

      // slave never ready
      @(posedge clk); #1;
      slv_en = 1'b0; m0_psel = 1; m0_penable = 0; m0_pwrite = 0; m0_paddr = 16'h0005;
`ifdef APB_IO_ARBITER_TIMEOUT_EN
      push(1'b0, 16'h0005, 1'b0, 8'h00, 1'b1);
`endif
      first_rdy = -1; to_at = -1; to_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (m0_pready && first_rdy < 0) first_rdy = i;
         if (timeout_err) begin
            to_cnt++;
            if (to_at < 0) to_at = i;
         end
         @(posedge clk); #1;
         m0_penable = m0_psel;
         if (first_rdy >= 0) begin m0_psel = 0; m0_penable = 0; end
      end
      @(negedge clk);
`ifdef APB_IO_ARBITER_TIMEOUT_EN
      chk("to_pready_cycle", 32'(first_rdy), 32'(6));
      chk("to_err_cycle", 32'(to_at), 32'(6));
      chk("to_err_pulses", 32'(to_cnt), 32'(1));
      chk("to_idle_gnt", 32'(gnt), 32'(0));
      chk("to_idle_psel", 32'(s_psel), 32'(0));
`else
      chk("noto_pready", 32'(first_rdy), 32'(-1));
      chk("noto_err", 32'(to_cnt), 32'(0));
      chk("noto_psel", 32'(s_psel), 32'(1));
      chk("noto_penable", 32'(s_penable), 32'(1));
      chk("noto_gnt", 32'(gnt), 32'(1));
`endif
      chk("sb_drained", 32'(sb.size()), 32'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
